sync_fifo_v2: RTL
=================

Name: sync_fifo_v2

Overview:
- Parametrised synchronous FIFO. Next generation of the team's 16x8 FIFO.
- Same port set and status flags as the current FIFO, plus:
  - arbitrary depth (power of two not required)
  - programmable almost-full and almost-empty thresholds
  - occupancy count output
  - compile-time first-word-fall-through read mode
- Sits between producer and consumer in one clock domain. It is the DUT for the UVM FIFO environment.

Parameters:
- FIFO_WIDTH, 16, data word width in bits (>=1).
- FIFO_DEPTH, 8, number of entries (>=2, any integer).
- AF_THRESH, FIFO_DEPTH-1, almostfull asserts when count >= AF_THRESH and count < FIFO_DEPTH.
- AE_THRESH, 1, almostempty asserts when count <= AE_THRESH and count > 0.
- Derived: max_fifo_addr = $clog2(FIFO_DEPTH); CNT_W = $clog2(FIFO_DEPTH+1).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  read data.
- wr_ack  output  1  registered; previous-cycle write accepted.
- overflow  output  1  registered; previous-cycle write rejected (full).
- underflow  output  1  registered; previous-cycle read rejected (empty).
- full  output  1  count == FIFO_DEPTH.
- empty  output  1  count == 0.
- almostfull  output  1  see AF_THRESH.
- almostempty  output  1  see AE_THRESH.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset:
  - Asynchronous assert on rst_n low; synchronous release.
  - wr_ptr, rd_ptr and count go to 0.
  - data_out, wr_ack, overflow and underflow go to 0.
  - Flags follow count, so empty=1 and the others are 0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents immediately.
- Accept rules, evaluated each edge from pre-edge state:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
- Simultaneous wr_en and rd_en:
  - When full: the read is accepted and the write is rejected (overflow=1). Count drops by 1.
  - When empty: the write is accepted and the read is rejected (underflow=1). Count rises by 1.
  - Otherwise both are accepted, and count is unchanged.
- Write: mem[wr_ptr] <= data_in. wr_ptr advances.
- Read (standard mode):
  - data_out <= mem[rd_ptr] at the accepting edge, giving 1-cycle latency. rd_ptr advances.
  - data_out holds its value when no read is accepted.
- Pointer wrap: next = (ptr == FIFO_DEPTH-1) ? 0 : ptr+1. Wrap is explicit and must be correct for non-power-of-two depth.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. It never exceeds FIFO_DEPTH and never goes below 0.
- wr_ack, overflow and underflow are registered pulses one cycle after the request. Each is cleared in any cycle without the corresponding event. wr_ack and overflow are mutually exclusive.
- full, empty, almostfull, almostempty and count are combinational from registered count. They are valid in the same cycle as the state change.
- Degenerate thresholds: if AF_THRESH >= FIFO_DEPTH, almostfull never asserts. If AE_THRESH == 0, almostempty never asserts.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally, valid whenever empty=0.
  - rd_en acts as a pop/acknowledge: the next word appears in the cycle after the accepted read.
  - While empty=1, data_out is don't-care.
  - underflow rules are unchanged.
- Undefined: standard registered read as described under Behaviour.
- Flags, count and acceptance rules are identical in both modes.

Decomposition:
- Package fifo_pkg contains:
  - default FIFO_WIDTH and FIFO_DEPTH localparams
  - function next_ptr(ptr, depth) implementing the wrap rule
  - function cnt_width(depth) returning $clog2(depth+1)
- One sub-module, fifo_mem: FIFO_DEPTH x FIFO_WIDTH storage with a synchronous write port and an asynchronous read port. It is used by both read modes.
- Pointers, count, flags and response registers stay in sync_fifo_v2.

Test Plan (FIFO_WIDTH=16, FIFO_DEPTH=6, AF_THRESH=5, AE_THRESH=1):
- Reset then idle: pulse rst_n low mid-cycle -> immediately empty=1, count=0, data_out=0, and wr_ack, overflow and underflow are 0.
- Fill: write 0x0001..0x0006 -> wr_ack=1 each following cycle; almostfull=1 at count=5; full=1 at count=6. A 7th write gives overflow=1, wr_ack=0, count=6.
- Drain (standard mode): read 6 times -> data_out = 0x0001..0x0006 one cycle after each rd_en; almostempty=1 at count=1; empty=1 at count=0. A 7th read gives underflow=1 and data_out holds 0x0006.
- Simultaneous at boundaries:
  - Full with wr_en=rd_en=1 -> overflow=1, read returns the oldest word, count=5.
  - Empty with wr_en=rd_en=1 -> underflow=1, wr_ack=1, count=1.
- Wrap with non-power-of-two depth: 20 cycles of alternating write/read with data 0x0100+i -> data order preserved across pointer wrap at 5->0; count stays within 0..1.
- FIFO_FWFT_EN build: write 0xABCD into an empty FIFO -> data_out=0xABCD with rd_en low in the cycle after the write. Assert rd_en -> empty=1 the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for sync_fifo_v2: default geometry, explicit pointer wrap, count width.
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    // Explicit wrap so any depth works, not only powers of two.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH, synchronous write port, asynchronous read port. Not reset.
module fifo_mem #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Parametrised single-clock FIFO with programmable almost flags and occupancy count.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_v2
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    localparam int CNT_W     = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [FIFO_WIDTH-1:0] rd_data;
    logic                  wr_acc, rd_acc;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    fifo_mem #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
            if (wr_acc) wr_ptr <= ADDR_W'(next_ptr(int'(wr_ptr), FIFO_DEPTH));
            if (rd_acc) rd_ptr <= ADDR_W'(next_ptr(int'(rd_ptr), FIFO_DEPTH));
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; rd_en only pops it.
    assign data_out = rd_data;
`else
    logic [FIFO_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dout_q <= '0;
        else if (rd_acc) dout_q <= rd_data;
    end

    assign data_out = dout_q;
`endif

    // Status is decoded from the registered count, so it tracks state in the same cycle.
    assign count       = cnt;
    assign full        = (cnt == CNT_W'(FIFO_DEPTH));
    assign empty       = (cnt == '0);
    assign almostfull  = (int'(cnt) >= AF_THRESH) && (int'(cnt) < FIFO_DEPTH);
    assign almostempty = (int'(cnt) <= AE_THRESH) && (cnt != '0);

endmodule
